dmem_arb: RTL and testbench

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 17 +
 rtl/dmem_arb.sv | 169 ++++++++++++++++
 tb/tb_dmem_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_MEM_BYTES  = 512;
  localparam int DEF_WORD_BYTES = 8;
  localparam int ID_W           = 1;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Arbitrates two load/store requesters onto a single data-memory port,
// one access per grant, with an out-of-range check taken at grant time.
//
// state  | meaning
// IDLE   | waiting for a request; grant is combinational
// ACCESS | memory read/write for the captured request (suppressed if out of range)
// RESP   | one-cycle rvalid/err pulse to the winner
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES  = DEF_MEM_BYTES,
  parameter int WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m0_wdata,
  input  logic [63:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic        m0_err,
  output logic        m1_err,
  output logic [63:0] m_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - WORD_BYTES);

  state_t      state_q, state_d;
  id_t         last_q, last_d;
  id_t         id_q, id_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;

  logic [1:0]  req;
  logic [1:0]  grant;
  logic        take;
  id_t         win_id;
  logic        win_we;
  logic [63:0] win_addr;
  logic [63:0] win_wdata;

  assign req = {m1_req, m0_req};

  rr_arb2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  assign take = (state_q == IDLE) && (grant != 2'b00);

  always_comb begin
    win_id    = id_t'(grant[1]);
    win_we    = grant[1] ? m1_we    : m0_we;
    win_addr  = grant[1] ? m1_addr  : m0_addr;
    win_wdata = grant[1] ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_q = 1 means m1 won last, so m0 takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= id_t'(1);
      id_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (take) begin
      last_d = win_id;
      id_d   = win_id;
      we_d   = win_we;
      err_d  = win_addr > MAX_ADDR;
      addr_d = win_addr;
      if (win_we) wdata_d = win_wdata;
    end
    if (state_q == ACCESS) begin
      if (err_q)      rdata_d = '0;
      else if (!we_q) rdata_d = mem_rdata;
    end
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          m0_gnt = grant[0];
          m1_gnt = grant[1];
        end
        ACCESS: begin
          mem_read  = !err_q && !we_q;
          mem_write = !err_q && we_q;
        end
        RESP: begin
          m0_rvalid = (id_q == id_t'(0));
          m1_rvalid = (id_q == id_t'(1));
          m0_err    = (id_q == id_t'(0)) && err_q;
          m1_err    = (id_q == id_t'(1)) && err_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: byte-array memory model plus a response scoreboard.
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [63:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [63:0] m_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  dmem_arb dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_we     (m0_we),
    .m1_we     (m1_we),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_err    (m0_err),
    .m1_err    (m1_err),
    .m_rdata   (m_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] mem [0:511];
  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [63:0] data;
    logic        chk;
  } exp_t;
  exp_t sb[$];

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 8; k++)
      mem_rdata[63-8*k -: 8] = mem[(int'(mem_addr[8:0]) + k) % 512];
  end

  always @(posedge clk) begin
    if (mem_write) begin
      wr_pulses <= wr_pulses + 1;
      for (int k = 0; k < 8; k++)
        mem[(int'(mem_addr[8:0]) + k) % 512] <= mem_wdata[63-8*k -: 8];
    end
    if (mem_read) rd_pulses <= rd_pulses + 1;
  end

  exp_t mon_e;
  logic mon_id, mon_err;
  always @(negedge clk) begin
    #2;
    if (m0_rvalid || m1_rvalid) begin
      checks++;
      if (m0_rvalid && m1_rvalid) begin
        errors++;
        $display("FAIL rvalid_both: m0_rvalid=%0b m1_rvalid=%0b, required one-hot", m0_rvalid, m1_rvalid);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: m0_rvalid=%0b m1_rvalid=%0b, required no response", m0_rvalid, m1_rvalid);
      end else begin
        mon_e   = sb.pop_front();
        mon_id  = m1_rvalid;
        mon_err = m1_rvalid ? m1_err : m0_err;
        if (mon_id !== mon_e.id || mon_err !== mon_e.err || (mon_e.chk && m_rdata !== mon_e.data)) begin
          errors++;
          $display("FAIL response: id=%0d err=%0b rdata=%h, required id=%0d err=%0b rdata=%h",
                   mon_id, mon_err, m_rdata, mon_e.id, mon_e.err, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives a request from just after a negedge and holds it until granted.
  // Returns at the negedge of the ACCESS cycle with req dropped.
  task automatic issue(input bit id, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, output int gcyc);
    gcyc = -1;
    if (id) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else    begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    for (int c = 0; c < 20; c++) begin
      #1;
      if ((id ? m1_gnt : m0_gnt) === 1'b1) begin gcyc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if (id) m1_req = 1'b0; else m0_req = 1'b0;
    checks++;
    if (gcyc < 0) begin
      errors++;
      $display("FAIL grant_timeout: m%0d not granted within 20 cycles", id);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 64'd0; m1_addr = 64'd8; m0_wdata = '1; m1_wdata = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b%b rvalid=%b%b err=%b%b rd=%b wr=%b, required all 0",
               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write);
    end
    checks++;
    if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || m_rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: mem_addr=%h mem_wdata=%h m_rdata=%h, required 0", mem_addr, mem_wdata, m_rdata);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: gnt=%b%b, required 00", m0_gnt, m1_gnt);
    end
    @(negedge clk);
  endtask

  task automatic test_single_load();
    int g;
    for (int k = 0; k < 8; k++) mem[8+k] = 8'(k + 1);
    sb.push_back('{id: 1'b0, err: 1'b0, data: 64'h0102030405060708, chk: 1'b1});
    issue(1'b0, 1'b0, 64'd8, 64'd0, g);
    checks++;
    if (g != 0) begin errors++; $display("FAIL load_gnt_cycle: got %0d, required 0", g); end
    #1;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 64'd8) begin
      errors++;
      $display("FAIL load_access: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=8", mem_read, mem_write, mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m_rdata !== 64'h0102030405060708 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL load_resp: rvalid=%b err=%b rdata=%h rd=%b, required 1 0 0102030405060708 0",
               m0_rvalid, m0_err, m_rdata, mem_read);
    end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int g, w0;
    w0 = wr_pulses;
    sb.push_back('{id: 1'b1, err: 1'b0, data: 64'd0, chk: 1'b0});
    issue(1'b1, 1'b1, 64'd16, 64'hDEADBEEFCAFEF00D, g);
    #1;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 64'd16 || mem_wdata !== 64'hDEADBEEFCAFEF00D) begin
      errors++;
      $display("FAIL store_access: wr=%b rd=%b addr=%h wdata=%h, required wr=1 rd=0 addr=16 wdata=deadbeefcafef00d",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    @(negedge clk); #1;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_err !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: rvalid=%b err=%b wr=%b, required 1 0 0", m1_rvalid, m1_err, mem_write);
    end
    @(negedge clk);
    sb.push_back('{id: 1'b1, err: 1'b0, data: 64'hDEADBEEFCAFEF00D, chk: 1'b1});
    issue(1'b1, 1'b0, 64'd16, 64'd0, g);
    @(negedge clk); #1;
    checks++;
    if (m1_rvalid !== 1'b1 || m_rdata !== 64'hDEADBEEFCAFEF00D) begin
      errors++;
      $display("FAIL store_readback: rvalid=%b rdata=%h, required 1 deadbeefcafef00d", m1_rvalid, m_rdata);
    end
    checks++;
    if (wr_pulses - w0 != 1) begin
      errors++;
      $display("FAIL store_write_cycles: got %0d, required 1", wr_pulses - w0);
    end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    logic [63:0] addrs [3];
    logic        errs  [3];
    logic [63:0] datas [3];
    int g, r0;
    for (int k = 0; k < 8; k++) mem[504+k] = 8'(8'hA0 + k);
    addrs[0] = 64'd504;                datas[0] = 64'hA0A1A2A3A4A5A6A7; errs[0] = 1'b0;
    addrs[1] = 64'd505;                datas[1] = 64'd0;                errs[1] = 1'b1;
    addrs[2] = 64'hFFFFFFFFFFFFFFFC;   datas[2] = 64'd0;                errs[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r0 = rd_pulses;
      sb.push_back('{id: 1'b0, err: errs[i], data: datas[i], chk: 1'b1});
      issue(1'b0, 1'b0, addrs[i], 64'd0, g);
      @(negedge clk); #1;
      checks++;
      if (m0_rvalid !== 1'b1 || m0_err !== errs[i] || m_rdata !== datas[i]) begin
        errors++;
        $display("FAIL boundary_%0d: rvalid=%b err=%b rdata=%h, required 1 %b %h",
                 i, m0_rvalid, m0_err, m_rdata, errs[i], datas[i]);
      end
      checks++;
      if (rd_pulses - r0 != (errs[i] ? 0 : 1)) begin
        errors++;
        $display("FAIL boundary_rd_%0d: mem_read cycles=%0d, required %0d", i, rd_pulses - r0, errs[i] ? 0 : 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    logic e0, e1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 64'd8;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 64'd16;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{id: 1'b0, err: 1'b0, data: 64'h0102030405060708, chk: 1'b1});
      sb.push_back('{id: 1'b1, err: 1'b0, data: 64'hDEADBEEFCAFEF00D, chk: 1'b1});
    end
    for (int c = 0; c < 10; c++) begin
      e0 = (c == 0) || (c == 6);
      e1 = (c == 3) || (c == 9);
      #1;
      checks++;
      if (m0_gnt !== e0 || m1_gnt !== e1) begin
        errors++;
        $display("FAIL contention_c%0d: gnt m0=%b m1=%b, required m0=%b m1=%b", c, m0_gnt, m1_gnt, e0, e1);
      end
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    int g, w0;
    logic [63:0] bytes;
    for (int k = 0; k < 8; k++) mem[24+k] = 8'h55;
    w0 = wr_pulses;
    issue(1'b0, 1'b1, 64'd24, 64'h1122334455667788, g);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_access: wr=%b rd=%b, required 0 0", mem_write, mem_read);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{id: 1'b0, err: 1'b0, data: 64'h5555555555555555, chk: 1'b1});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 64'd24;
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: gnt=%b rvalid=%b, required gnt=1 rvalid=0", m0_gnt, m0_rvalid);
    end
    bytes = '0;
    for (int k = 0; k < 8; k++) bytes[63-8*k -: 8] = mem[24+k];
    checks++;
    if (bytes !== 64'h5555555555555555 || wr_pulses != w0) begin
      errors++;
      $display("FAIL rst_mem: bytes=%h writes=%0d, required 5555555555555555 and 0 writes", bytes, wr_pulses - w0);
    end
    @(negedge clk);
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stability();
    sb.push_back('{id: 1'b0, err: 1'b0, data: 64'h0102030405060708, chk: 1'b1});
    sb.push_back('{id: 1'b1, err: 1'b0, data: 64'hDEADBEEFCAFEF00D, chk: 1'b1});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 64'd8;
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL stab_m0_gnt: got %b, required 1", m0_gnt); end
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 64'd504;
    #1;
    checks++;
    if (m1_gnt !== 1'b0) begin errors++; $display("FAIL stab_wait1: m1_gnt=%b, required 0", m1_gnt); end
    @(negedge clk);
    m1_addr = 64'd16;
    #1;
    checks++;
    if (m1_gnt !== 1'b0) begin errors++; $display("FAIL stab_wait2: m1_gnt=%b, required 0", m1_gnt); end
    @(negedge clk); #1;
    checks++;
    if (m1_gnt !== 1'b1) begin errors++; $display("FAIL stab_m1_gnt: got %b, required 1", m1_gnt); end
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 64'd16 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL stab_addr: mem_addr=%h rd=%b, required 0x10 1", mem_addr, mem_read);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    test_reset();
    test_single_load();
    test_store_load();
    test_boundary();
    test_contention();
    test_reset_mid_store();
    test_stability();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: %0d outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
